// File: rtl/dna_port_reader_if.sv
// Bundle of request/status signals and the DNA_PORT pins for dna_port_reader.
// The slave modport is the reader itself; the master modport is the surrounding logic.
interface dna_port_reader_if #(
    parameter int DNA_WIDTH = 57
);
    logic                 rd_req;
    logic                 dna_dout;
    logic                 dna_clk;
    logic                 dna_read;
    logic                 dna_shift;
    logic [DNA_WIDTH-1:0] dna_id;
    logic                 dna_rdy;
    logic                 dna_busy;
    logic                 dna_err;

    modport master (
        output rd_req, dna_dout,
        input  dna_clk, dna_read, dna_shift, dna_id, dna_rdy, dna_busy, dna_err
    );

    modport slave (
        input  rd_req, dna_dout,
        output dna_clk, dna_read, dna_shift, dna_id, dna_rdy, dna_busy, dna_err
    );
endinterface

// File: rtl/dna_port_reader.sv
// Sequences the 7-series DNA_PORT (DCLK/READ/SHIFT) and captures the device DNA.
// Optional macro DNA_DOUBLE_READ_EN: two passes per request, up to 3 attempts on mismatch.
//
// state | meaning
// IDLE  | waiting for auto-start after reset or for rd_req
// LOAD  | READ high; one DCLK rising edge loads the DNA_PORT shift register
// SHIFT | SHIFT high; one DOUT sample taken just before each DCLK rising edge
// DONE  | publish dna_id, raise dna_rdy, drop dna_busy, park DCLK low
module dna_port_reader #(
    parameter int CLK_DIV    = 2,
    parameter int DNA_WIDTH  = 57,
    parameter bit AUTO_START = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_nrst,
    dna_port_reader_if.slave  port_io
);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam int         BW       = $clog2(DNA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t               state_q;
    logic [7:0]           div_cnt_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [DNA_WIDTH-1:0] sreg_q;
    logic [DNA_WIDTH-1:0] id_q;
    logic                 dna_clk_q;
    logic                 dna_read_q;
    logic                 dna_shift_q;
    logic                 rdy_q;
    logic                 busy_q;
    logic                 auto_done_q;
`ifdef DNA_DOUBLE_READ_EN
    logic [DNA_WIDTH-1:0] cmp_q;
    logic                 pass_q;
    logic [1:0]           attempt_q;
    logic                 err_q;
`endif

    logic wrap;
    logic rise_evt;
    logic fall_evt;

    assign wrap     = busy_q && (div_cnt_q == DIV_LAST);
    assign rise_evt = wrap && !dna_clk_q;
    assign fall_evt = wrap &&  dna_clk_q;

    // READ/SHIFT only switch on a DCLK falling edge, so they are settled long before the next rise.
    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            sreg_q      <= '0;
            id_q        <= '0;
            dna_clk_q   <= 1'b0;
            dna_read_q  <= 1'b0;
            dna_shift_q <= 1'b0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
            auto_done_q <= 1'b0;
`ifdef DNA_DOUBLE_READ_EN
            cmp_q       <= '0;
            pass_q      <= 1'b0;
            attempt_q   <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            if (busy_q) begin
                if (wrap) begin
                    div_cnt_q <= '0;
                    dna_clk_q <= !dna_clk_q;
                end else begin
                    div_cnt_q <= div_cnt_q + 8'd1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (port_io.rd_req || (AUTO_START && !auto_done_q)) begin
                        auto_done_q <= 1'b1;
                        state_q     <= LOAD;
                        busy_q      <= 1'b1;
                        rdy_q       <= 1'b0;
                        dna_read_q  <= 1'b1;
                        bit_cnt_q   <= '0;
`ifdef DNA_DOUBLE_READ_EN
                        pass_q      <= 1'b0;
                        attempt_q   <= '0;
                        err_q       <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (fall_evt) begin
                        state_q     <= SHIFT;
                        dna_read_q  <= 1'b0;
                        dna_shift_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (rise_evt) begin
                        sreg_q    <= {sreg_q[DNA_WIDTH-2:0], port_io.dna_dout};
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                    end
                    // The edge after the last sample is let through; the pass ends on its fall.
                    if (fall_evt && (bit_cnt_q == BW'(DNA_WIDTH))) begin
`ifdef DNA_DOUBLE_READ_EN
                        if (!pass_q) begin
                            cmp_q       <= sreg_q;
                            pass_q      <= 1'b1;
                            state_q     <= LOAD;
                            dna_read_q  <= 1'b1;
                            dna_shift_q <= 1'b0;
                            bit_cnt_q   <= '0;
                        end else if (sreg_q == cmp_q) begin
                            state_q <= DONE;
                        end else if (attempt_q == 2'd2) begin
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                            err_q       <= 1'b1;
                            id_q        <= '0;
                            dna_shift_q <= 1'b0;
                            dna_clk_q   <= 1'b0;
                            div_cnt_q   <= '0;
                        end else begin
                            attempt_q   <= attempt_q + 2'd1;
                            pass_q      <= 1'b0;
                            state_q     <= LOAD;
                            dna_read_q  <= 1'b1;
                            dna_shift_q <= 1'b0;
                            bit_cnt_q   <= '0;
                        end
`else
                        state_q <= DONE;
`endif
                    end
                end
                DONE: begin
                    id_q        <= sreg_q;
                    rdy_q       <= 1'b1;
                    busy_q      <= 1'b0;
                    dna_shift_q <= 1'b0;
                    dna_clk_q   <= 1'b0;
                    div_cnt_q   <= '0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign port_io.dna_clk   = dna_clk_q;
    assign port_io.dna_read  = dna_read_q;
    assign port_io.dna_shift = dna_shift_q;
    assign port_io.dna_id    = id_q;
    assign port_io.dna_rdy   = rdy_q;
    assign port_io.dna_busy  = busy_q;
`ifdef DNA_DOUBLE_READ_EN
    assign port_io.dna_err   = err_q;
`else
    assign port_io.dna_err   = 1'b0;
`endif
endmodule

// File: tb/tb_dna_port_reader.sv
// Directed bench for dna_port_reader: three instances (auto/div2, manual/div1, manual/div5)
// each driven by a behavioural DNA_PORT model.
module tb_dna_port_reader;
    localparam int W = 57;
`ifdef DNA_DOUBLE_READ_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif
    localparam logic [W-1:0] DNA_A    = 57'h123456789ABCDEF;
    localparam logic [W-1:0] DNA_ONES = 57'h1FFFFFFFFFFFFFF;
    localparam logic [W-1:0] DNA_ALT  = 57'h0AAAAAAAAAAAAAA;

    logic sys_clk = 1'b0;
    logic nrst_a  = 1'b0;
    logic nrst_m  = 1'b0;
    always #5 sys_clk = ~sys_clk;

    dna_port_reader_if #(.DNA_WIDTH(W)) if_a ();
    dna_port_reader_if #(.DNA_WIDTH(W)) if_b ();
    dna_port_reader_if #(.DNA_WIDTH(W)) if_c ();

    dna_port_reader #(.CLK_DIV(2), .DNA_WIDTH(W), .AUTO_START(1'b1)) dut_a (
        .sys_clk(sys_clk), .sys_nrst(nrst_a), .port_io(if_a));
    dna_port_reader #(.CLK_DIV(1), .DNA_WIDTH(W), .AUTO_START(1'b0)) dut_b (
        .sys_clk(sys_clk), .sys_nrst(nrst_m), .port_io(if_b));
    dna_port_reader #(.CLK_DIV(5), .DNA_WIDTH(W), .AUTO_START(1'b0)) dut_c (
        .sys_clk(sys_clk), .sys_nrst(nrst_m), .port_io(if_c));

    logic [2:0] rdq = 3'b000;
    assign if_a.rd_req = rdq[0];
    assign if_b.rd_req = rdq[1];
    assign if_c.rd_req = rdq[2];

    // DNA_PORT models: load on READ, shift MSB-first on SHIFT, both on DCLK rise
    logic [W-1:0] src_a = DNA_A, src_b = DNA_A, src_c = DNA_ALT;
    logic [W-1:0] sr_a = '0, sr_b = '0, sr_c = '0;
    int edges_a = 0, redges_a = 0, flip_mode = 0, load_base = 0;

    function automatic logic [W-1:0] flip_mask(input int rel);
        logic [W-1:0] m;
        m = '0;
        if ((flip_mode == 1 && rel == 1) || (flip_mode == 2 && (rel % 2) == 1)) m[0] = 1'b1;
        return m;
    endfunction

    always @(posedge if_a.dna_clk) begin
        edges_a <= edges_a + 1;
        if (if_a.dna_read) begin
            redges_a <= redges_a + 1;
            sr_a     <= src_a ^ flip_mask(redges_a - load_base);
        end else if (if_a.dna_shift) begin
            sr_a <= {sr_a[W-2:0], 1'b0};
        end
    end
    always @(posedge if_b.dna_clk)
        if (if_b.dna_read) sr_b <= src_b;
        else if (if_b.dna_shift) sr_b <= {sr_b[W-2:0], 1'b0};
    always @(posedge if_c.dna_clk)
        if (if_c.dna_read) sr_c <= src_c;
        else if (if_c.dna_shift) sr_c <= {sr_c[W-2:0], 1'b0};
    assign if_a.dna_dout = sr_a[W-1];
    assign if_b.dna_dout = sr_b[W-1];
    assign if_c.dna_dout = sr_c[W-1];

    logic [2:0] m_clk, m_read, m_shift, m_busy, m_rdy, m_err;
    logic [W-1:0] m_id [3];
    assign m_clk   = {if_c.dna_clk,   if_b.dna_clk,   if_a.dna_clk};
    assign m_read  = {if_c.dna_read,  if_b.dna_read,  if_a.dna_read};
    assign m_shift = {if_c.dna_shift, if_b.dna_shift, if_a.dna_shift};
    assign m_busy  = {if_c.dna_busy,  if_b.dna_busy,  if_a.dna_busy};
    assign m_rdy   = {if_c.dna_rdy,   if_b.dna_rdy,   if_a.dna_rdy};
    assign m_err   = {if_c.dna_err,   if_b.dna_err,   if_a.dna_err};
    assign m_id[0] = if_a.dna_id;
    assign m_id[1] = if_b.dna_id;
    assign m_id[2] = if_c.dna_id;

    // Sticky monitors sampled on the falling sys_clk edge
    int tcyc = 0;
    int last_r [3] = '{-1, -1, -1};
    int gmin   [3] = '{1000000, 1000000, 1000000};
    int gmax   [3] = '{0, 0, 0};
    logic [2:0] p_clk = '0, p_read = '0, p_shift = '0;
    logic [2:0] overlap = '0, bad_chg = '0, active = '0;
    logic watch_idle = 1'b0;

    always @(negedge sys_clk) begin
        tcyc <= tcyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (m_read[i] && m_shift[i]) overlap[i] <= 1'b1;
            if (((m_read[i] != p_read[i]) || (m_shift[i] != p_shift[i])) && m_clk[i]) bad_chg[i] <= 1'b1;
            if (watch_idle && (m_clk[i] || m_read[i] || m_shift[i] || m_busy[i])) active[i] <= 1'b1;
            if (!m_busy[i]) begin
                last_r[i] <= -1;
            end else if (m_clk[i] && !p_clk[i]) begin
                if (last_r[i] >= 0) begin
                    if (tcyc - last_r[i] < gmin[i]) gmin[i] <= tcyc - last_r[i];
                    if (tcyc - last_r[i] > gmax[i]) gmax[i] <= tcyc - last_r[i];
                end
                last_r[i] <= tcyc;
            end
        end
        p_clk   <= m_clk;
        p_read  <= m_read;
        p_shift <= m_shift;
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lat(input int div);
        return NPASS * (W + 1) * 2 * div + 2;
    endfunction

    function automatic int near(input int got, input int exp);
        return (got >= exp - 1 && got <= exp + 1) ? exp : got;
    endfunction

    task automatic wait_rdy(input int i, input int start, input int lim, output int cyc);
        cyc = start;
        while (!m_rdy[i] && cyc < lim) begin
            @(posedge sys_clk); #1;
            cyc++;
        end
    endtask

    task automatic pulse(input int i);
        @(negedge sys_clk); rdq[i] = 1'b1;
        @(posedge sys_clk); #1; rdq[i] = 1'b0;
    endtask

    initial begin
        int cyc, e0, r0;
        logic id_moved;

        repeat (3) @(negedge sys_clk);
        chk("rst_outs", {m_clk[0], m_read[0], m_shift[0], m_rdy[0], m_busy[0], m_err[0]}, 6'b0);
        chk("rst_id", m_id[0], 0);

        e0 = edges_a; r0 = redges_a;
        @(negedge sys_clk); nrst_a = 1'b1; nrst_m = 1'b1; watch_idle = 1'b1;
        wait_rdy(0, 0, 3000, cyc);
        chk("auto_lat", near(cyc, lat(2)), lat(2));
        chk("auto_id", m_id[0], DNA_A);
        chk("auto_rises", edges_a - e0, 58 * NPASS);
        chk("auto_read_rises", redges_a - r0, NPASS);
        chk("auto_busy_low", m_busy[0], 0);

        repeat (900) @(posedge sys_clk);
        #1 watch_idle = 1'b0;
        chk("idle_b_quiet", active[1], 0);
        chk("idle_c_quiet", active[2], 0);

        pulse(1);
        wait_rdy(1, 1, 3000, cyc);
        chk("b_lat", near(cyc, lat(1)), lat(1));
        chk("b_id", m_id[1], DNA_A);
        src_b = DNA_ALT;
        pulse(1);
        wait_rdy(1, 1, 3000, cyc);
        chk("b_id_alt", m_id[1], DNA_ALT);
        pulse(2);
        wait_rdy(2, 1, 5000, cyc);
        chk("c_lat", near(cyc, lat(5)), lat(5));
        chk("c_id_alt", m_id[2], DNA_ALT);
        chk("a_period_min", gmin[0], 4);
        chk("a_period_max", gmax[0], 4);
        chk("b_period_min", gmin[1], 2);
        chk("b_period_max", gmax[1], 2);
        chk("c_period_min", gmin[2], 10);
        chk("c_period_max", gmax[2], 10);

        // Re-read with new content; a second request while busy must be ignored
        src_a = DNA_ONES; e0 = edges_a;
        pulse(0);
        chk("reread_rdy_drop", m_rdy[0], 0);
        chk("reread_busy", m_busy[0], 1);
        cyc = 1; id_moved = 1'b0;
        while (!m_rdy[0] && cyc < 3000) begin
            rdq[0] = (cyc == 20);
            if (m_id[0] != DNA_A) id_moved = 1'b1;
            @(posedge sys_clk); #1;
            cyc++;
        end
        rdq[0] = 1'b0;
        chk("reread_id_held", id_moved, 0);
        chk("reread_lat", near(cyc, lat(2)), lat(2));
        chk("reread_id", m_id[0], DNA_ONES);
        chk("reread_rises", edges_a - e0, 58 * NPASS);

        // Asynchronous reset in the middle of SHIFT
        src_a = DNA_A;
        pulse(0);
        cyc = 0;
        while (!m_shift[0] && cyc < 100) begin @(posedge sys_clk); #1; cyc++; end
        repeat (100) @(posedge sys_clk);
        #2;
        chk("midrst_was_busy", m_busy[0], 1);
        nrst_a = 1'b0;
        #1;
        chk("midrst_outs", {m_clk[0], m_read[0], m_shift[0], m_rdy[0], m_busy[0], m_err[0]}, 6'b0);
        chk("midrst_id", m_id[0], 0);
        @(negedge sys_clk); nrst_a = 1'b1; e0 = edges_a;
        wait_rdy(0, 0, 3000, cyc);
        chk("midrst_rerun_lat", near(cyc, lat(2)), lat(2));
        chk("midrst_rerun_id", m_id[0], DNA_A);
        chk("midrst_rerun_rises", edges_a - e0, 58 * NPASS);

`ifdef DNA_DOUBLE_READ_EN
        load_base = redges_a; flip_mode = 1;
        pulse(0);
        wait_rdy(0, 1, 5000, cyc);
        chk("dbl_retry_lat", near(cyc, 2 * lat(2) - 2), 2 * lat(2) - 2);
        chk("dbl_retry_id", m_id[0], DNA_A);
        chk("dbl_retry_loads", redges_a - load_base, 4);
        chk("dbl_retry_err", m_err[0], 0);

        load_base = redges_a; flip_mode = 2;
        pulse(0);
        cyc = 1;
        while (!m_err[0] && cyc < 10000) begin @(posedge sys_clk); #1; cyc++; end
        chk("dbl_err", m_err[0], 1);
        chk("dbl_err_rdy", m_rdy[0], 0);
        chk("dbl_err_id", m_id[0], 0);
        chk("dbl_err_busy", m_busy[0], 0);
        chk("dbl_err_loads", redges_a - load_base, 6);
        flip_mode = 0;
        pulse(0);
        chk("dbl_err_clear", m_err[0], 0);
        wait_rdy(0, 1, 5000, cyc);
        chk("dbl_clean_id", m_id[0], DNA_A);
`endif

        repeat (4) @(negedge sys_clk);
        chk("no_overlap", overlap, 0);
        chk("rw_change_clk_low", bad_chg, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dna_port_reader.md
Name: dna_port_reader

Overview:
- Drives the 7-series DNA_PORT primitive pins: DCLK, READ and SHIFT out, DOUT in.
- Serially captures the 57-bit device DNA.
- Presents the result as dna_id / dna_rdy to the AXI register slave downstream.
- Runs in the 24 MHz ip_sys_clk domain; DCLK is generated internally by clock-enable division.

Parameters:
- CLK_DIV, 2, sys_clk cycles per DCLK half-period (DCLK = sys_clk / (2*CLK_DIV)); legal range 1..255.
- DNA_WIDTH, 57, number of DNA bits captured.
- AUTO_START, 1, 1 = read automatically after reset release; 0 = wait for rd_req.

Ports:
- sys_clk  in  1  block clock, 24 MHz
- sys_nrst  in  1  asynchronous active-low reset
- rd_req  in  1  single-cycle pulse; starts a (re)read when not busy
- dna_dout  in  1  DNA_PORT DOUT
- dna_clk  out  1  DNA_PORT DCLK
- dna_read  out  1  DNA_PORT READ
- dna_shift  out  1  DNA_PORT SHIFT
- dna_id  out  DNA_WIDTH  captured DNA, MSB = first bit shifted out
- dna_rdy  out  1  dna_id valid
- dna_busy  out  1  read sequence in progress
- dna_err  out  1  read-back mismatch (optional feature only)

Behaviour:
- Interface: one clock, sys_clk. Reset sys_nrst is asynchronous, active-low.
- Reset values:
  - all outputs 0
  - FSM in IDLE
  - divider count 0, bit count 0
- Divider:
  - div_cnt counts 0..CLK_DIV-1 only while busy.
  - On wrap, dna_clk toggles. dna_clk idles low outside busy states.
  - rise_evt = wrap while dna_clk == 0; the next cycle dna_clk is 1.
- FSM states:
  - IDLE
    - Go to LOAD one cycle after reset release if AUTO_START = 1, or on rd_req.
    - Entering LOAD: dna_busy = 1, dna_rdy = 0, dna_id keeps its old value.
  - LOAD
    - dna_read = 1, dna_shift = 0.
    - Stay for exactly one rise_evt, then go to SHIFT.
    - DNA_PORT loads on that DCLK rising edge; DOUT then shows bit 56.
  - SHIFT
    - dna_read = 0, dna_shift = 1.
    - On each rise_evt, before the edge is applied: shift_reg <= {shift_reg[DNA_WIDTH-2:0], dna_dout}, bit_cnt++.
    - After DNA_WIDTH samples, go to DONE. The 57th shift edge is harmless.
  - DONE
    - One cycle. dna_id <= shift_reg, dna_rdy = 1, dna_busy = 0, dna_shift = 0, dna_clk forced low, divider cleared.
    - Return to IDLE.
- Latency:
  - dna_rdy rises (DNA_WIDTH+1)*2*CLK_DIV + 2 sys_clk cycles after LOAD entry, ±1.
  - CLK_DIV = 2, DNA_WIDTH = 57: 234 cycles.
- rd_req:
  - Ignored while dna_busy.
  - rd_req in the same cycle as DONE is ignored.
  - rd_req in IDLE with dna_rdy = 1 restarts the sequence; dna_rdy drops the next cycle.
- dna_dout is sampled raw. It is on-die and DCLK-derived, so no synchronizer is used.
- Reset mid-read: everything returns to reset values immediately; dna_id clears to 0; with AUTO_START = 1 the read reruns after release.
- dna_read and dna_shift are never high together. Both change only in cycles where dna_clk is low and its next value is low.

Optional Feature:
- Macro: DNA_DOUBLE_READ_EN
- Defined:
  - Each request performs two full LOAD/SHIFT passes; pass 1 is held in a compare register.
  - Match: DONE as above.
  - Mismatch: retry both passes, up to 3 attempts total.
  - After the 3rd mismatch: dna_err = 1, dna_rdy stays 0, dna_id = 0, FSM returns to IDLE.
  - dna_err clears on the next rd_req or on reset.
  - Latency roughly doubles per attempt.
- Undefined: single pass; dna_err tied 0; no compare register is synthesized.

Test Plan:
- Behavioural DNA_PORT model loaded with 57'h123456789ABCDEF, AUTO_START = 1, CLK_DIV = 2, reset released -> dna_rdy = 1 at 234±1 cycles, dna_id = 57'h123456789ABCDEF, exactly 58 dna_clk rising edges, dna_read high over exactly 1 of them.
- AUTO_START = 0, no rd_req for 1000 cycles -> dna_clk, dna_read, dna_shift, dna_busy all stay 0. Then a rd_req pulse -> same dna_id as the first test.
- After completion, change model to 57'h1FFFFFFFFFFFFFF and pulse rd_req -> dna_rdy low next cycle, dna_id holds 57'h123456789ABCDEF until new dna_rdy, then 57'h1FFFFFFFFFFFFFF. A second rd_req while busy changes nothing.
- Assert sys_nrst after 100 SHIFT cycles -> all outputs 0 asynchronously. After release, a full read completes with the correct value.
- CLK_DIV = 1 and CLK_DIV = 5 with pattern 57'h0AAAAAAAAAAAAAA -> correct capture; dna_clk period 2 and 10 cycles respectively; READ/SHIFT never overlap (assertion).
- DNA_DOUBLE_READ_EN defined:
  - Model flips bit 0 on the 2nd pass only -> correct dna_id after one retry.
  - Model mismatches always -> dna_err = 1 after 3 attempts, dna_rdy = 0.
